// File: rtl/decode_rr_arbiter.sv
// Round-robin arbiter for one 8-way shared resource: registered winner index,
// decoded one-hot grant, and a bound on consecutive grant cycles under contention.
module decode_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clka,
    input  logic       rst,
    input  logic       E,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       gnt_new
);

    // Handshake: there is no back-pressure. gnt_valid=1 means grant/gnt_idx name
    // the owner this cycle; gnt_new=1 marks the first cycle of each grant.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     r_state;
    logic [2:0] r_last;
    logic [7:0] r_hold;
    logic [2:0] r_idx;
    logic       r_valid;
    logic       r_new;
    logic [7:0] r_grant;

    state_t     w_state;
    logic [2:0] w_last;
    logic [7:0] w_hold;
    logic [2:0] w_idx;
    logic       w_valid;
    logic       w_new;
    logic [7:0] w_grant;
    logic [7:0] w_others;

    // First set bit of mask scanning upward from last+1, wrapping through last.
    function automatic logic [2:0] pick(input logic [2:0] last, input logic [7:0] mask);
        logic [2:0] idx;
        logic       found;
        idx   = last;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && mask[3'(last + 3'(k))]) begin
                idx   = 3'(last + 3'(k));
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign w_others = req & ~(8'd1 << r_idx);

    always_comb begin
        w_state = r_state;
        w_last  = r_last;
        w_hold  = r_hold;
        w_idx   = r_idx;
        w_valid = r_valid;
        w_new   = 1'b0;
        case (r_state)
            IDLE: begin
                w_valid = 1'b0;
                if (E && (req != 8'd0)) begin
                    w_state = GRANT;
                    w_idx   = pick(r_last, req);
                    w_valid = 1'b1;
                    w_new   = 1'b1;
                    w_hold  = 8'd0;
                end
            end
            GRANT: begin
                if (!E) begin
                    w_state = IDLE;
                    w_valid = 1'b0;
                    w_last  = r_idx;
                    w_hold  = 8'd0;
                end else if (!req[r_idx]) begin
                    w_last = r_idx;
                    w_hold = 8'd0;
                    if (req != 8'd0) begin
                        w_idx = pick(r_idx, req);
                        w_new = 1'b1;
                    end else begin
                        w_state = IDLE;
                        w_valid = 1'b0;
                    end
                end else if ((r_hold == HOLD_LAST) && (w_others != 8'd0)) begin
                    w_last = r_idx;
                    w_idx  = pick(r_idx, w_others);
                    w_new  = 1'b1;
                    w_hold = 8'd0;
                end else if (r_hold != HOLD_LAST) begin
                    w_hold = r_hold + 8'd1;
                end
            end
            default: begin
                w_state = IDLE;
                w_valid = 1'b0;
            end
        endcase
        w_grant = w_valid ? (8'd1 << w_idx) : 8'd0;
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 3'd7;
            r_hold  <= 8'd0;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
            r_new   <= 1'b0;
            r_grant <= 8'd0;
        end else begin
            r_state <= w_state;
            r_last  <= w_last;
            r_hold  <= w_hold;
            r_idx   <= w_idx;
            r_valid <= w_valid;
            r_new   <= w_new;
            r_grant <= w_grant;
        end
    end

    assign grant     = r_grant;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;
    assign gnt_new   = r_new;

endmodule

// File: tb/tb_decode_rr_arbiter.sv
// Randomized and directed bench for decode_rr_arbiter: a reference model
// queues the expected outputs per cycle, a monitor pops and compares them.
module tb_decode_rr_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clka;
    logic       rst;
    logic       E;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       gnt_new;

    decode_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clka      (clka),
        .rst       (rst),
        .E         (E),
        .req       (req),
        .grant     (grant),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .gnt_new   (gnt_new)
    );

    // clock / reset block
    initial clka = 1'b0;
    always #5 clka = ~clka;

    // expected entry: {grant[7:0], idx[2:0], valid, new}
    logic [12:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    // reference model: who owns the resource and for how many cycles so far
    int m_valid = 0;
    int m_idx   = 0;
    int m_last  = 7;
    int m_run   = 0;
    int m_new   = 0;

    function automatic int rr_pick(input int from, input logic [7:0] mask);
        for (int k = 1; k <= 8; k++) begin
            if (mask[(from + k) % 8]) return (from + k) % 8;
        end
        return from;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [7:0] q);
        logic [7:0] others;
        m_new = 0;
        if (r) begin
            m_valid = 0; m_idx = 0; m_last = 7; m_run = 0;
        end else if (!m_valid) begin
            if (e && q != 0) begin
                m_idx = rr_pick(m_last, q); m_valid = 1; m_new = 1; m_run = 1;
            end
        end else begin
            others = q;
            others[m_idx] = 1'b0;
            if (!e) begin
                m_last = m_idx; m_valid = 0;
            end else if (!q[m_idx]) begin
                m_last = m_idx;
                if (q != 0) begin
                    m_idx = rr_pick(m_last, q); m_new = 1; m_run = 1;
                end else begin
                    m_valid = 0;
                end
            end else if (m_run >= MAX_HOLD && others != 0) begin
                m_last = m_idx;
                m_idx = rr_pick(m_last, others); m_new = 1; m_run = 1;
            end else if (m_run < MAX_HOLD) begin
                m_run = m_run + 1;
            end
        end
    endtask

    // driver task: one clock cycle of stimulus plus its expected response
    task automatic step(input logic r, input logic e, input logic [7:0] q);
        logic [7:0] g;
        @(negedge clka);
        rst = r; E = e; req = q;
        model_step(r, e, q);
        g = m_valid ? (8'd1 << m_idx) : 8'd0;
        exp_q.push_back({g, 3'(m_idx), 1'(m_valid), 1'(m_new)});
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // monitor / scoreboard
    initial begin
        logic [12:0] e;
        forever begin
            @(posedge clka);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("grant",     int'(grant),     int'(e[12:5]));
                check("gnt_idx",   int'(gnt_idx),   int'(e[4:2]));
                check("gnt_valid", int'(gnt_valid), int'(e[1]));
                check("gnt_new",   int'(gnt_new),   int'(e[0]));
            end
        end
    end

    initial begin
        logic [7:0] q;
        rst = 1'b1; E = 1'b0; req = 8'h00;

        // reset then idle
        step(1, 0, 8'h00); step(1, 0, 8'h00);
        repeat (3) step(0, 1, 8'h00);

        // single requester held 10 cycles, then released
        repeat (10) step(0, 1, 8'h20);
        repeat (2) step(0, 1, 8'h00);

        // round-robin rotation: the granted requester drops for one cycle
        step(1, 1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            q = 8'h81;
            if (m_valid != 0) q[m_idx] = 1'b0;
            step(0, 1, q);
        end

        // preemption under constant contention
        step(1, 1, 8'h00);
        repeat (14) step(0, 1, 8'h06);

        // enable drop mid-grant on idx 3
        step(1, 1, 8'h00);
        repeat (2) step(0, 1, 8'h08);
        repeat (2) step(0, 0, 8'h08);
        repeat (3) step(0, 1, 8'h18);

        // reset mid-grant on idx 6
        step(1, 1, 8'h00);
        repeat (2) step(0, 1, 8'h40);
        step(1, 1, 8'h40);
        repeat (3) step(0, 1, 8'h41);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            q = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) q = 8'h00;
            step(($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0, q);
        end

        // drain the last expected entry
        @(negedge clka);
        @(negedge clka);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
